// File: rtl/freq_smoother_pkg.sv
// Shared types and default constants for the pitch-to-ball frequency smoother.
package freq_smoother_pkg;

  localparam int unsigned FREQ_W              = 16;
  localparam int unsigned CNT_W               = 8;
  localparam int unsigned SHIFT_W             = 4;

  localparam int unsigned DEF_MIN_FREQ        = 80;
  localparam int unsigned DEF_MAX_FREQ        = 1020;
  localparam int unsigned DEF_REST_FREQ       = 400;
  localparam int unsigned DEF_ALPHA_SHIFT     = 2;
  localparam int unsigned DEF_SILENCE_FRAMES  = 8;

  typedef enum logic {
    SILENT   = 1'b0,
    TRACKING = 1'b1
  } state_e;

  // Inclusive range gate applied to raw detector samples.
  function automatic logic in_range(input logic [FREQ_W-1:0] f,
                                    input logic [FREQ_W-1:0] lo,
                                    input logic [FREQ_W-1:0] hi);
    return (f >= lo) && (f <= hi);
  endfunction

endpackage

// File: rtl/freq_smoother_ema_step.sv
// One exponential-moving-average step: acc + ((sample - acc) >>> shift), floor rounding.
module ema_step
  import freq_smoother_pkg::*;
(
  input  logic [FREQ_W-1:0]  acc_i,
  input  logic [FREQ_W-1:0]  sample_i,
  input  logic [SHIFT_W-1:0] shift_i,
  output logic [FREQ_W-1:0]  acc_next_o
);

  logic signed [FREQ_W:0] diff_c;
  logic signed [FREQ_W:0] step_c;

  // 17-bit signed so a falling target produces a negative, floor-shifted step.
  always_comb begin
    diff_c     = $signed({1'b0, sample_i}) - $signed({1'b0, acc_i});
    step_c     = diff_c >>> shift_i;
    acc_next_o = FREQ_W'($signed({1'b0, acc_i}) + step_c);
  end

endmodule

// File: rtl/freq_smoother.sv
// Range-gates raw pitch samples, smooths them with an EMA and latches the result once per video frame.
module freq_smoother
  import freq_smoother_pkg::*;
#(
  parameter int unsigned MIN_FREQ       = DEF_MIN_FREQ,
  parameter int unsigned MAX_FREQ       = DEF_MAX_FREQ,
  parameter int unsigned ALPHA_SHIFT    = DEF_ALPHA_SHIFT,
  parameter int unsigned SILENCE_FRAMES = DEF_SILENCE_FRAMES,
  parameter int unsigned REST_FREQ      = DEF_REST_FREQ
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [FREQ_W-1:0] raw_freq_in,
  input  logic              raw_valid_in,
  input  logic              new_frame_in,
  output logic [FREQ_W-1:0] freq_out,
  output logic              freq_valid_out,
  output logic              silent_out
);

  localparam logic [FREQ_W-1:0]  MIN_L    = FREQ_W'(MIN_FREQ);
  localparam logic [FREQ_W-1:0]  MAX_L    = FREQ_W'(MAX_FREQ);
  localparam logic [FREQ_W-1:0]  REST_L   = FREQ_W'(REST_FREQ);
  localparam logic [SHIFT_W-1:0] SHIFT_L  = SHIFT_W'(ALPHA_SHIFT);
  localparam logic [CNT_W-1:0]   SIL_L    = CNT_W'(SILENCE_FRAMES);
  localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};

  state_e              state_q, state_d;
  logic [FREQ_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    silence_cnt_q, silence_cnt_d;
  logic [FREQ_W-1:0]   freq_q, freq_d;
  logic                freq_valid_q, freq_valid_d;
  logic                silent_q, silent_d;

  logic                accept_c;
  logic [FREQ_W-1:0]   ema_next_c;
  logic [CNT_W-1:0]    cnt_inc_c;

  ema_step u_ema_step (
    .acc_i      (acc_q),
    .sample_i   (raw_freq_in),
    .shift_i    (SHIFT_L),
    .acc_next_o (ema_next_c)
  );

  assign accept_c  = raw_valid_in && in_range(raw_freq_in, MIN_L, MAX_L);
  assign cnt_inc_c = (silence_cnt_q == CNT_MAX) ? CNT_MAX : silence_cnt_q + CNT_W'(1);

  // Next-state: tracking FSM, silence counter and frame latch.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    silence_cnt_d = silence_cnt_q;
    freq_d        = freq_q;
    freq_valid_d  = 1'b0;
    silent_d      = (state_q == SILENT);

    unique case (state_q)
      SILENT: begin
        if (accept_c) begin
          acc_d         = raw_freq_in;
          silence_cnt_d = '0;
          state_d       = TRACKING;
        end
      end
      TRACKING: begin
        if (accept_c) begin
          acc_d         = ema_next_c;
          silence_cnt_d = '0;
        end else if (new_frame_in) begin
          silence_cnt_d = cnt_inc_c;
          if (cnt_inc_c == SIL_L) begin
            state_d = SILENT;
          end
        end
      end
      default: state_d = SILENT;
    endcase

    // Latch uses the pre-update acc and the state before this edge's transition.
    if (new_frame_in) begin
      freq_d       = (state_q == TRACKING) ? acc_q : REST_L;
      freq_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= SILENT;
      acc_q         <= '0;
      silence_cnt_q <= '0;
      freq_q        <= REST_L;
      freq_valid_q  <= 1'b0;
      silent_q      <= 1'b1;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      silence_cnt_q <= silence_cnt_d;
      freq_q        <= freq_d;
      freq_valid_q  <= freq_valid_d;
      silent_q      <= silent_d;
    end
  end

  assign freq_out       = freq_q;
  assign freq_valid_out = freq_valid_q;
  assign silent_out     = silent_q;

endmodule

// File: tb/tb_freq_smoother.sv
// Directed bench for freq_smoother: behavioural model feeds a scoreboard of expected frame outputs.
module tb_freq_smoother;

  logic        clk;
  logic        rst;
  logic [15:0] raw_freq;
  logic        raw_valid;
  logic        new_frame;
  logic [15:0] freq_out;
  logic        freq_valid_out;
  logic        silent_out;

  int checks = 0;
  int errors = 0;

  // Bench model state
  int          m_acc;
  int          m_cnt;
  bit          m_tracking;
  logic [15:0] sb[$];

  freq_smoother dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .raw_freq_in    (raw_freq),
    .raw_valid_in   (raw_valid),
    .new_frame_in   (new_frame),
    .freq_out       (freq_out),
    .freq_valid_out (freq_valid_out),
    .silent_out     (silent_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus; model is advanced and outputs checked after the edge.
  task automatic step(input logic v, input logic [15:0] f, input logic nf);
    logic exp_silent;
    bit   acc_ok;
    int   fi;
    @(negedge clk);
    raw_valid = v;
    raw_freq  = f;
    new_frame = nf;
    fi         = int'(f);
    acc_ok     = v && (fi >= 80) && (fi <= 1020);
    exp_silent = !m_tracking;
    if (nf) sb.push_back(m_tracking ? 16'(m_acc) : 16'd400);
    if (!m_tracking) begin
      if (acc_ok) begin
        m_acc      = fi;
        m_cnt      = 0;
        m_tracking = 1'b1;
      end
    end else if (acc_ok) begin
      m_acc = m_acc + ((fi - m_acc) >>> 2);
      m_cnt = 0;
    end else if (nf) begin
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      if (m_cnt == 8) m_tracking = 1'b0;
    end
    @(posedge clk);
    #1;
    check1("freq_valid", freq_valid_out, nf);
    if (freq_valid_out === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_underflow: observed valid=1 expected no pending frame");
      end
      if (sb.size() != 0) check16("sb_freq", freq_out, sb.pop_front());
    end
    check1("silent", silent_out, exp_silent);
    raw_valid = 1'b0;
    new_frame = 1'b0;
  endtask

  task automatic sample(input logic [15:0] f);
    step(1'b1, f, 1'b0);
  endtask

  task automatic frame();
    step(1'b0, 16'd0, 1'b1);
  endtask

  // Reset asserted between clock edges; outputs must react without a clock.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check16({tag, "_freq"}, freq_out, 16'd400);
    check1({tag, "_silent"}, silent_out, 1'b1);
    check1({tag, "_valid"}, freq_valid_out, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_acc      = 0;
    m_cnt      = 0;
    m_tracking = 1'b0;
    sb.delete();
  endtask

  initial begin
    rst        = 1'b1;
    raw_freq   = '0;
    raw_valid  = 1'b0;
    new_frame  = 1'b0;
    m_acc      = 0;
    m_cnt      = 0;
    m_tracking = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check16("rst_freq", freq_out, 16'd400);
    check1("rst_silent", silent_out, 1'b1);
    check1("rst_valid", freq_valid_out, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Frame while silent presents the rest frequency
    frame();
    check16("silent_frame", freq_out, 16'd400);

    // Cold start
    sample(16'd800);
    frame();
    check16("cold_start", freq_out, 16'd800);
    step(1'b0, 16'd0, 1'b0);
    check1("cold_valid_single", freq_valid_out, 1'b0);
    check16("cold_hold", freq_out, 16'd800);

    // Step response toward 1000; extra samples between frames stay invisible
    sample(16'd1000);
    frame();
    check16("step_850", freq_out, 16'd850);
    sample(16'd1000);
    check16("step_hidden", freq_out, 16'd850);
    frame();
    check16("step_887", freq_out, 16'd887);
    sample(16'd1000);
    frame();
    check16("step_915", freq_out, 16'd915);
    sample(16'd1000);
    frame();
    check16("step_936", freq_out, 16'd936);

    // Falling target converges exactly with floor rounding
    async_reset("rst_a");
    sample(16'd1000);
    frame();
    check16("load_1000", freq_out, 16'd1000);
    sample(16'd998);
    frame();
    check16("round_999", freq_out, 16'd999);
    sample(16'd998);
    frame();
    check16("round_998", freq_out, 16'd998);
    sample(16'd998);
    frame();
    check16("round_hold", freq_out, 16'd998);
    sample(16'd50);
    sample(16'd1100);
    sample(16'd79);
    sample(16'd1021);
    frame();
    check16("reject_hold", freq_out, 16'd998);

    // Silence: rejected samples mid-count must not restart the counter
    async_reset("rst_b");
    sample(16'd600);
    repeat (3) frame();
    sample(16'd50);
    sample(16'd1100);
    repeat (4) frame();
    check1("sil_not_yet", silent_out, 1'b0);
    frame();
    check16("sil_8th", freq_out, 16'd600);
    frame();
    check1("sil_rise", silent_out, 1'b1);
    check16("sil_9th", freq_out, 16'd400);
    sample(16'd300);
    frame();
    check16("sil_reload", freq_out, 16'd300);

    // Range boundaries are inclusive
    async_reset("rst_c");
    sample(16'd80);
    frame();
    check16("bound_min", freq_out, 16'd80);
    sample(16'd1020);
    frame();
    check16("bound_max", freq_out, 16'd315);

    // Collision at silence_cnt=7: sample wins, latch shows pre-sample acc
    async_reset("rst_d");
    sample(16'd500);
    repeat (7) frame();
    step(1'b1, 16'd700, 1'b1);
    check16("collide_pre", freq_out, 16'd500);
    step(1'b0, 16'd0, 1'b0);
    check1("collide_no_silent", silent_out, 1'b0);
    repeat (7) frame();
    check16("collide_acc", freq_out, 16'd550);
    frame();
    frame();
    check1("collide_late_silent", silent_out, 1'b1);

    // Reset mid-tracking, then direct load
    sample(16'd700);
    frame();
    sample(16'd900);
    async_reset("rst_e");
    sample(16'd900);
    frame();
    check16("post_rst_load", freq_out, 16'd900);

    repeat (2) step(1'b0, 16'd0, 1'b0);
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_leftover: observed %0d pending expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
